// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array input feeder.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } feeder_state_t;

    localparam int unsigned DEF_ROW = 4;
    localparam int unsigned DEF_COL = 4;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned BEAT_W = cnt_width(DEF_ROW * DEF_COL);

endpackage

// File: rtl/skew_line.sv
// Fixed-depth registered delay line carrying a data word and its enable.
module skew_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_en,
    output logic [WIDTH-1:0] o_data
);

    logic [DEPTH-1:0] r_en;
    logic [WIDTH-1:0] r_data [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_en <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_en[0]   <= i_en;
            r_data[0] <= i_data;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_en[i]   <= r_en[i-1];
                r_data[i] <= r_data[i-1];
            end
        end
    end

    assign o_en   = r_en[DEPTH-1];
    assign o_data = r_data[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Systolic array input driver: column-wise weight load, then row-skewed
// feature streaming with matching per-row enables.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ROW   = 4,
    parameter int COL   = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic [CNT_W-1:0]     num_vec_in,
    input  logic                 w_valid_in,
    output logic                 w_ready_out,
    input  logic [WIDTH-1:0]     w_data_in,
    input  logic                 f_valid_in,
    output logic                 f_ready_out,
    input  logic [ROW*WIDTH-1:0] f_data_in,
    output logic                 ctrl_out,
    output logic [COL-1:0]       weight_en_out,
    output logic [COL*WIDTH-1:0] weight_data_out,
    output logic [ROW*WIDTH-1:0] feature_out,
    output logic [ROW-1:0]       in_en_out,
    output logic                 busy_out,
    output logic                 done_out
);

    localparam int unsigned BW = cnt_width(ROW * COL);
    localparam int unsigned CW = cnt_width(COL);
    localparam int unsigned DW = cnt_width(ROW);

    feeder_state_t r_state;
    feeder_state_t w_next;

    logic [BW-1:0]        r_beat;
    logic [DW-1:0]        r_drain;
    logic [CNT_W-1:0]     r_num_vec;
    logic [CNT_W-1:0]     r_vcnt;
    logic                 r_ctrl;
    logic [COL-1:0]       r_wen;
    logic [COL*WIDTH-1:0] r_wdata;

    logic          w_w_acc;
    logic          w_f_acc;
    logic          w_last_beat;
    logic          w_last_vec;
    logic          w_last_drain;
    logic [CW-1:0] w_col;

    assign w_ready_out  = (r_state == LOAD_W);
    assign f_ready_out  = (r_state == STREAM);
    assign w_w_acc      = w_valid_in & w_ready_out;
    assign w_f_acc      = f_valid_in & f_ready_out;
    assign w_last_beat  = (r_beat == BW'(ROW * COL - 1));
    assign w_last_vec   = (r_vcnt == r_num_vec - CNT_W'(1));
    assign w_last_drain = (r_drain == DW'(ROW - 1));
    assign w_col        = CW'(int'(r_beat) / ROW);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= IDLE;
            r_ctrl  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= (w_next == LOAD_W);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start_in) w_next = LOAD_W;
            LOAD_W:  if (w_w_acc && w_last_beat) w_next = (r_num_vec == '0) ? DONE : STREAM;
            STREAM:  if (w_f_acc && w_last_vec) w_next = DRAIN;
            DRAIN:   if (w_last_drain) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_beat    <= '0;
            r_drain   <= '0;
            r_num_vec <= '0;
            r_vcnt    <= '0;
        end else begin
            if (r_state == IDLE && start_in) begin
                r_num_vec <= num_vec_in;
                r_vcnt    <= '0;
            end
            if (w_w_acc) begin
                r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
            end
            if (w_f_acc) begin
                r_vcnt <= r_vcnt + 1'b1;
            end
            if (r_state == DRAIN) begin
                r_drain <= w_last_drain ? '0 : r_drain + 1'b1;
            end
        end
    end

    // Weight outputs are a one-cycle echo of the accepted beat, zero otherwise.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wen   <= '0;
            r_wdata <= '0;
        end else begin
            r_wen   <= '0;
            r_wdata <= '0;
            if (w_w_acc) begin
                r_wen[w_col]                  <= 1'b1;
                r_wdata[w_col*WIDTH +: WIDTH] <= w_data_in;
            end
        end
    end

    for (genvar r = 0; r < ROW; r++) begin : g_row
        logic [WIDTH-1:0] w_lane;

        assign w_lane = w_f_acc ? f_data_in[r*WIDTH +: WIDTH] : '0;

        skew_line #(
            .WIDTH (WIDTH),
            .DEPTH (r + 1)
        ) u_skew (
            .i_clk  (clk_in),
            .i_rst  (rst_in),
            .i_en   (w_f_acc),
            .i_data (w_lane),
            .o_en   (in_en_out[r]),
            .o_data (feature_out[r*WIDTH +: WIDTH])
        );
    end

    assign ctrl_out        = r_ctrl;
    assign weight_en_out   = r_wen;
    assign weight_data_out = r_wdata;
    assign busy_out        = (r_state != IDLE);
    assign done_out        = (r_state == DONE);

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: job table plus scoreboard of
// expected weight and skewed feature outputs.
module tb_systolic_feeder;

    localparam int WIDTH = 8;
    localparam int ROW   = 4;
    localparam int COL   = 4;
    localparam int CNT_W = 16;
    localparam int NBEAT = ROW * COL;

    logic                 clk = 1'b0;
    logic                 rst_in;
    logic                 start_in;
    logic [CNT_W-1:0]     num_vec_in;
    logic                 w_valid_in;
    logic                 w_ready_out;
    logic [WIDTH-1:0]     w_data_in;
    logic                 f_valid_in;
    logic                 f_ready_out;
    logic [ROW*WIDTH-1:0] f_data_in;
    logic                 ctrl_out;
    logic [COL-1:0]       weight_en_out;
    logic [COL*WIDTH-1:0] weight_data_out;
    logic [ROW*WIDTH-1:0] feature_out;
    logic [ROW-1:0]       in_en_out;
    logic                 busy_out;
    logic                 done_out;

    always #5 clk = ~clk;

    systolic_feeder #(
        .WIDTH (WIDTH),
        .ROW   (ROW),
        .COL   (COL),
        .CNT_W (CNT_W)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst_in),
        .start_in        (start_in),
        .num_vec_in      (num_vec_in),
        .w_valid_in      (w_valid_in),
        .w_ready_out     (w_ready_out),
        .w_data_in       (w_data_in),
        .f_valid_in      (f_valid_in),
        .f_ready_out     (f_ready_out),
        .f_data_in       (f_data_in),
        .ctrl_out        (ctrl_out),
        .weight_en_out   (weight_en_out),
        .weight_data_out (weight_data_out),
        .feature_out     (feature_out),
        .in_en_out       (in_en_out),
        .busy_out        (busy_out),
        .done_out        (done_out)
    );

    typedef struct {
        int                   due;
        logic [COL-1:0]       en;
        logic [COL*WIDTH-1:0] data;
    } wexp_t;

    typedef struct {
        int               due;
        logic [WIDTH-1:0] data;
    } fexp_t;

    typedef struct {
        int n;
        bit gap;
        bit mid_start;
        int exp_ctrl;
        int exp_fready;
        int exp_busy;
        int exp_dly;
    } job_t;

    wexp_t wq[$];
    fexp_t fq[ROW][$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wbeat = 0;
    int w_acc = 0;
    int f_acc = 0;
    int last_w_cyc = 0;
    int last_f_cyc = 0;
    int ndone = 0;
    int done_cyc = 0;
    int ctrl_cyc = 0;
    int fready_cyc = 0;
    int busy_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [ROW*WIDTH-1:0] vec(input int base, input int i);
        logic [ROW*WIDTH-1:0] v;
        v = '0;
        for (int r = 0; r < ROW; r++) begin
            v[r*WIDTH +: WIDTH] = WIDTH'(base + 4 * i + r + 1);
        end
        return v;
    endfunction

    task automatic check_outputs();
        wexp_t            we;
        fexp_t            fe;
        logic [WIDTH-1:0] lane;
        if (wq.size() > 0 && wq[0].due == cyc) begin
            we = wq.pop_front();
            chk("weight_en", 64'(weight_en_out), 64'(we.en));
            chk("weight_data", 64'(weight_data_out), 64'(we.data));
        end else begin
            chk("weight_en_quiet", 64'(weight_en_out), 0);
            chk("weight_data_quiet", 64'(weight_data_out), 0);
        end
        for (int r = 0; r < ROW; r++) begin
            lane = feature_out[r*WIDTH +: WIDTH];
            if (fq[r].size() > 0 && fq[r][0].due == cyc) begin
                fe = fq[r].pop_front();
                chk($sformatf("in_en_row%0d", r), 64'(in_en_out[r]), 1);
                chk($sformatf("lane_row%0d", r), 64'(lane), 64'(fe.data));
            end else begin
                chk($sformatf("in_en_bubble_row%0d", r), 64'(in_en_out[r]), 0);
                chk($sformatf("lane_bubble_row%0d", r), 64'(lane), 0);
            end
        end
        chk("w_ready_vs_ctrl", 64'(w_ready_out), 64'(ctrl_out));
        chk("ready_exclusive", 64'(w_ready_out & f_ready_out), 0);
    endtask

    // One clock: check this cycle's outputs, book accepted beats/vectors.
    task automatic step();
        wexp_t we;
        fexp_t fe;
        int    col;
        @(negedge clk);
        check_outputs();
        if (w_valid_in && w_ready_out) begin
            col     = wbeat / ROW;
            we.due  = cyc + 1;
            we.en   = '0;
            we.en[col] = 1'b1;
            we.data = '0;
            we.data[col*WIDTH +: WIDTH] = w_data_in;
            wq.push_back(we);
            wbeat      = (wbeat + 1) % NBEAT;
            w_acc++;
            last_w_cyc = cyc;
        end
        if (f_valid_in && f_ready_out) begin
            for (int r = 0; r < ROW; r++) begin
                fe.due  = cyc + 1 + r;
                fe.data = f_data_in[r*WIDTH +: WIDTH];
                fq[r].push_back(fe);
            end
            f_acc++;
            last_f_cyc = cyc;
        end
        if (done_out) begin
            ndone++;
            done_cyc = cyc;
        end
        ctrl_cyc   += int'(ctrl_out);
        fready_cyc += int'(f_ready_out);
        busy_cyc   += int'(busy_out);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load_weights();
        int w0;
        w0 = w_acc;
        w_valid_in = 1'b1;
        for (int k = 0; k < 200 && (w_acc - w0) < NBEAT; k++) begin
            w_data_in = WIDTH'(w_acc - w0 + 1);
            step();
        end
        w_valid_in = 1'b0;
        w_data_in  = '0;
        chk("weight_beats_accepted", 64'(w_acc - w0), 64'(NBEAT));
    endtask

    task automatic run_job(input int jn, input job_t j);
        int  d0;
        int  sent;
        int  a0;
        bit  prev_acc;
        d0         = ndone;
        ctrl_cyc   = 0;
        fready_cyc = 0;
        busy_cyc   = 0;
        num_vec_in = CNT_W'(j.n);
        start_in   = 1'b1;
        step();
        start_in   = 1'b0;
        num_vec_in = '1;
        load_weights();
        sent     = 0;
        prev_acc = 1'b0;
        for (int k = 0; k < 500 && sent < j.n; k++) begin
            f_valid_in = !(j.gap && prev_acc);
            f_data_in  = vec(jn * 32, sent);
            if (j.mid_start && sent == 1) begin
                start_in   = 1'b1;
                num_vec_in = CNT_W'(7);
            end else begin
                start_in = 1'b0;
            end
            a0 = f_acc;
            step();
            prev_acc = (f_acc != a0);
            if (prev_acc) sent++;
        end
        start_in   = 1'b0;
        f_valid_in = (j.n == 0);
        f_data_in  = vec(jn * 32, 0);
        for (int k = 0; k < 64 && ndone == d0; k++) begin
            step();
        end
        repeat (3) step();
        f_valid_in = 1'b0;
        f_data_in  = '0;
        chk($sformatf("job%0d_done_count", jn), 64'(ndone - d0), 1);
        if (j.n == 0)
            chk($sformatf("job%0d_done_delay", jn), 64'(done_cyc - last_w_cyc), 64'(j.exp_dly));
        else
            chk($sformatf("job%0d_done_delay", jn), 64'(done_cyc - last_f_cyc), 64'(j.exp_dly));
        chk($sformatf("job%0d_ctrl_cycles", jn), 64'(ctrl_cyc), 64'(j.exp_ctrl));
        chk($sformatf("job%0d_fready_cycles", jn), 64'(fready_cyc), 64'(j.exp_fready));
        chk($sformatf("job%0d_busy_cycles", jn), 64'(busy_cyc), 64'(j.exp_busy));
        chk($sformatf("job%0d_wq_drained", jn), 64'(wq.size()), 0);
        for (int r = 0; r < ROW; r++) begin
            chk($sformatf("job%0d_fq%0d_drained", jn, r), 64'(fq[r].size()), 0);
        end
        chk($sformatf("job%0d_idle_after", jn), 64'(busy_out), 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl"}, 64'(ctrl_out), 0);
        chk({tag, "_w_ready"}, 64'(w_ready_out), 0);
        chk({tag, "_f_ready"}, 64'(f_ready_out), 0);
        chk({tag, "_busy"}, 64'(busy_out), 0);
        chk({tag, "_done"}, 64'(done_out), 0);
        chk({tag, "_weight_en"}, 64'(weight_en_out), 0);
        chk({tag, "_weight_data"}, 64'(weight_data_out), 0);
        chk({tag, "_feature"}, 64'(feature_out), 0);
        chk({tag, "_in_en"}, 64'(in_en_out), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        job_t jobs[5];
        int   a0;
        int   d0;

        // n, gap, mid_start, ctrl cycles, f_ready cycles, busy cycles, done delay
        jobs[0] = '{n: 3, gap: 1'b0, mid_start: 1'b0, exp_ctrl: 16, exp_fready: 3, exp_busy: 24, exp_dly: 5};
        jobs[1] = '{n: 2, gap: 1'b1, mid_start: 1'b0, exp_ctrl: 16, exp_fready: 3, exp_busy: 24, exp_dly: 5};
        jobs[2] = '{n: 0, gap: 1'b0, mid_start: 1'b0, exp_ctrl: 16, exp_fready: 0, exp_busy: 17, exp_dly: 1};
        jobs[3] = '{n: 3, gap: 1'b0, mid_start: 1'b1, exp_ctrl: 16, exp_fready: 3, exp_busy: 24, exp_dly: 5};
        jobs[4] = '{n: 5, gap: 1'b1, mid_start: 1'b0, exp_ctrl: 16, exp_fready: 9, exp_busy: 30, exp_dly: 5};

        rst_in     = 1'b1;
        start_in   = 1'b0;
        num_vec_in = '0;
        w_valid_in = 1'b0;
        w_data_in  = '0;
        f_valid_in = 1'b0;
        f_data_in  = '0;
        #3;
        check_all_zero("reset");
        step();
        step();
        rst_in = 1'b0;
        repeat (2) step();

        for (int i = 0; i < 5; i++) begin
            run_job(i, jobs[i]);
        end

        // Reset in the middle of STREAM with data still in the skew pipes.
        num_vec_in = CNT_W'(5);
        start_in   = 1'b1;
        step();
        start_in = 1'b0;
        load_weights();
        a0 = f_acc;
        f_valid_in = 1'b1;
        for (int k = 0; k < 20 && (f_acc - a0) < 2; k++) begin
            f_data_in = vec(200, f_acc - a0);
            step();
        end
        f_valid_in = 1'b0;
        f_data_in  = '0;
        chk("midrst_pre_f_ready", 64'(f_ready_out), 1);
        chk("midrst_pre_row0_en", 64'(in_en_out[0]), 1);
        d0 = ndone;
        rst_in = 1'b1;
        #1;
        check_all_zero("midrst");
        wq.delete();
        for (int r = 0; r < ROW; r++) fq[r].delete();
        wbeat = 0;
        step();
        step();
        rst_in = 1'b0;
        repeat (6) step();
        chk("midrst_no_done", 64'(ndone - d0), 0);
        chk("midrst_idle", 64'(busy_out), 0);

        // A normal job after the abort must still run cleanly.
        run_job(5, jobs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
Input-side driver for the systolic array. It accepts a weight stream and a feature-vector stream over valid/ready handshakes and emits the array's stimulus: per-column weight enables and data, then row-skewed feature data with matching per-row input enables. It sits between the on-chip feature/weight buffers and the array. Row r is delayed r cycles so the array sees the triangular wavefront it expects.

Parameters:
WIDTH, 8, bits per weight/feature element
ROW, 4, array rows (feature lanes)
COL, 4, array columns (weight lanes)
CNT_W, 16, width of the job vector count

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  asynchronous active-high reset
start_in  input  1  job start pulse; sampled only in IDLE
num_vec_in  input  CNT_W  feature vectors in job; latched on accepted start
w_valid_in  input  1  weight beat valid
w_ready_out  output  1  weight beat accepted when valid&ready
w_data_in  input  WIDTH  weight element
f_valid_in  input  1  feature vector valid
f_ready_out  output  1  feature vector accepted when valid&ready
f_data_in  input  ROW*WIDTH  feature vector; lane r at bits [r*WIDTH +: WIDTH]
ctrl_out  output  1  array mode: 1 during weight load, 0 otherwise
weight_en_out  output  COL  one-hot column weight enable
weight_data_out  output  COL*WIDTH  per-column weight data
feature_out  output  ROW*WIDTH  skewed feature lanes to array
in_en_out  output  ROW  skewed per-row enables
busy_out  output  1  high in any state except IDLE
done_out  output  1  one-cycle pulse at job end

Behaviour:
- Reset (async, rst_in=1): state IDLE, counters 0, skew pipes cleared, every output 0. Reset mid-job aborts immediately; no done_out.
- FSM: IDLE -> LOAD_W on start_in. LOAD_W -> STREAM after ROW*COL weight beats, or -> DONE if latched num_vec = 0. STREAM -> DRAIN on the cycle the num_vec-th vector is accepted. DRAIN -> DONE after ROW cycles. DONE -> IDLE unconditionally, done_out=1 for that cycle only.
- start_in outside IDLE is ignored.
- w_ready_out = (state==LOAD_W); f_ready_out = (state==STREAM). Both are combinational from state only and never depend on valid.
- ctrl_out = (state==LOAD_W), registered with state.
- Weight beats: beat k (0..ROW*COL-1) targets column k/ROW, column 0 first. On the cycle after acceptance, weight_en_out has only bit k/ROW set and that column's data slice equals the beat. All other slices are 0. With no acceptance, weight_en_out = 0 and data = 0.
- Feature skew: a vector accepted at cycle t drives lane r of feature_out and in_en_out[r]=1 at cycle t+1+r.
- Stall cycles (valid low in STREAM) insert a bubble: enable 0 and lane data 0 in that slot, skewed identically.
- Skew pipes keep shifting in DRAIN. Each lane emits its data once; there are no duplicates or drops.
- The final lane (ROW-1) emits at most on the last DRAIN cycle. done_out follows on the next cycle.
- Counters: the beat counter wraps to 0 on leaving LOAD_W. The vector counter is CNT_W bits; num_vec = 2^CNT_W-1 is legal.

Decomposition:
- Package systolic_pkg: state enum feeder_state_t {IDLE, LOAD_W, STREAM, DRAIN, DONE}; beat-counter width constant $clog2(ROW*COL).
- Sub-module skew_line (parameters WIDTH, DEPTH): registered delay line of data plus enable, async reset to 0. Instantiate it once per row with DEPTH = r+1.

Test Plan:
- Reset mid-STREAM (ROW=COL=4, 2 vectors accepted, then rst_in pulse) -> all outputs 0 the same cycle, state IDLE, no done_out.
- Weight load with beats 1..16, w_valid always high -> 16 cycles with ctrl_out=1. Beats 1-4 produce weight_en_out=4'b0001 with col0 data 1,2,3,4; beats 13-16 produce 4'b1000 with data 13..16. Then STREAM.
- num_vec=3, vectors {0x04030201, 0x08070605, 0x0C0B0A09} back-to-back -> row0 gets 1,5,9 at t+1..t+3 and row3 gets 4,8,C at t+4..t+6. in_en_out follows the same pattern. done_out pulses once, 4 cycles after the last acceptance +1.
- num_vec=2 with a one-cycle f_valid gap between vectors -> every lane shows enable pattern 1,0,1 shifted by r. Bubble data is 0.
- num_vec=0 -> after 16 weight beats: DONE, done_out pulse, f_ready_out never asserted.
- start_in asserted during STREAM -> ignored; latched num_vec unchanged; single done_out.
